fir_filter_mc: RTL

Time-multiplexed, multi-channel FIR filter with a single multiply-accumulate engine and runtime-loadable coefficients. It sits after the ADC capture path, where one instance filters `CH` interleaved ADC streams instead of one fully parallel filter per channel. Compared with the parallel fixed-coefficient filter, it trades throughput for area. It adds a valid/ready handshake, per-channel history, output scaling and optional saturation.

---
 rtl/fir_filter_mc.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fir_filter_mc.sv
// fir_filter_mc
// Time-multiplexed multi-channel FIR filter. One multiply-accumulate engine
// serves CH interleaved input streams, one sample at a time. Each channel has
// its own TAPS-deep circular sample history. All channels share one
// runtime-loadable coefficient bank.
//
// Ports
//   clk, n_rst     clock; asynchronous active-low reset
//   din/din_ch     input sample and its channel, qualified by din_valid
//   din_valid      sample offered
//   din_ready      block can accept a sample (IDLE and out of reset)
//   coef_we/_addr/_data   coefficient write, honoured only in IDLE
//   coef_err       one-cycle pulse after a coefficient write is rejected
//   dout/dout_ch   filtered result and its channel, held until the next result
//   dout_valid     one-cycle result strobe
//   sat            one-cycle pulse with dout_valid when the result clipped
//   dbg_state_o    current FSM state, for observation only
//
// Handshake: a sample transfers on a rising clk edge where din_valid and
// din_ready are both high. din_ready does not depend on din_valid.
//
// Build option: define FIR_MC_SAT_EN to clamp out-of-range results and
// drive sat. Otherwise the result wraps to OW bits and sat is tied to 0.
module fir_filter_mc #(
    parameter int WIDTH = 14,
    parameter int TAPS  = 32,
    parameter int CH    = 2,
    parameter int CW    = 16,
    parameter int OW    = 30,
    parameter int SHIFT = 0,
    localparam int CHW  = $clog2(CH),
    localparam int TW   = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] din,
    input  logic [CHW-1:0]   din_ch,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             coef_we,
    input  logic [TW-1:0]    coef_addr,
    input  logic [CW-1:0]    coef_data,
    output logic             coef_err,
    output logic [OW-1:0]    dout,
    output logic [CHW-1:0]   dout_ch,
    output logic             dout_valid,
    output logic             sat,
    output logic [1:0]       dbg_state_o
);
    localparam int PW   = WIDTH + CW;
    localparam int ACCW = PW + TW;
    localparam bit CH_POW2 = (CH == (1 << CHW));

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    tap_q, tap_d;
    logic [TW-1:0]    newest_q, newest_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [ACCW-1:0]  acc_q, acc_d, acc_sum;
    logic [PW-1:0]    prod_q, prod_d, mult;
    logic [OW-1:0]    dout_q, dout_d, dout_n;
    logic [CHW-1:0]   dout_ch_q, dout_ch_d;
    logic             dout_valid_q, dout_valid_d;
    logic             sat_q, sat_d, sat_n;
    logic             coef_err_q, coef_err_d;

    logic [WIDTH-1:0] hist_q [CH][TAPS];
    logic [TW-1:0]    wr_ptr_q [CH];
    logic [CW-1:0]    coef_q [TAPS];

    logic             accept, ch_ok;
    logic [TW-1:0]    rd_idx;
    logic [WIDTH-1:0] x_rd;
    logic [CW-1:0]    c_rd;
    logic [PW-1:0]    x_ext, c_ext;

    assign din_ready = n_rst && (state_q == S_IDLE);
    assign accept    = din_valid && din_ready;

    // Out-of-range channel numbers exist only for non-power-of-2 CH.
    generate
        if (CH_POW2) begin : g_ch_pow2
            assign ch_ok = 1'b1;
        end else begin : g_ch_npow2
            assign ch_ok = (int'(din_ch) < CH);
        end
    endgenerate

    // Tap k pairs coef[k] with the sample k positions older than the newest.
    assign rd_idx = newest_q - tap_q;
    assign x_rd   = hist_q[ch_q][rd_idx];
    assign c_rd   = coef_q[tap_q];
    assign x_ext  = {{CW{x_rd[WIDTH-1]}}, x_rd};
    assign c_ext  = {{WIDTH{c_rd[CW-1]}}, c_rd};
    assign mult   = $signed(x_ext) * $signed(c_ext);

    // The product register lags the tap read by one cycle; prod_q is zeroed
    // on accept so the first MAC cycle adds nothing.
    assign acc_sum = acc_q + {{TW{prod_q[PW-1]}}, prod_q};

`ifdef FIR_MC_SAT_EN
    logic [ACCW-1:0]    shifted;
    logic [ACCW-OW:0]   hi;
    logic               ovf;
    assign shifted = $signed(acc_sum) >>> SHIFT;
    // In range only when all bits from the OW-1 sign position upward agree.
    assign hi      = shifted[ACCW-1:OW-1];
    assign ovf     = !((&hi) || !(|hi));
    assign dout_n  = ovf ? {shifted[ACCW-1], {(OW-1){~shifted[ACCW-1]}}}
                         : shifted[OW-1:0];
    assign sat_n   = ovf;
`else
    assign dout_n  = OW'($signed(acc_sum) >>> SHIFT);
    assign sat_n   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        newest_d     = newest_q;
        ch_d         = ch_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = 1'b0;
        sat_d        = 1'b0;
        coef_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && ch_ok) begin
                    state_d  = S_MAC;
                    tap_d    = '0;
                    ch_d     = din_ch;
                    newest_d = wr_ptr_q[din_ch];
                    acc_d    = '0;
                    prod_d   = '0;
                end
            end
            S_MAC: begin
                acc_d      = acc_sum;
                prod_d     = mult;
                tap_d      = tap_q + TW'(1);
                coef_err_d = coef_we;
                if (tap_q == TW'(TAPS - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                acc_d        = acc_sum;
                dout_d       = dout_n;
                dout_ch_d    = ch_q;
                dout_valid_d = 1'b1;
                sat_d        = sat_n;
                coef_err_d   = coef_we;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            newest_q     <= '0;
            ch_q         <= '0;
            acc_q        <= '0;
            prod_q       <= '0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            coef_err_q   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                wr_ptr_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
            // Impulse pass-through until coefficients are loaded.
            for (int t = 0; t < TAPS; t++) begin
                coef_q[t] <= (t == 0) ? CW'(1) : '0;
            end
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            newest_q     <= newest_d;
            ch_q         <= ch_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            sat_q        <= sat_d;
            coef_err_q   <= coef_err_d;
            if (accept && ch_ok) begin
                hist_q[din_ch][wr_ptr_q[din_ch]] <= din;
                wr_ptr_q[din_ch]                 <= wr_ptr_q[din_ch] + TW'(1);
            end
            // Writing in IDLE lands before any same-edge accept reads it.
            if (coef_we && (state_q == S_IDLE)) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    assign dout        = dout_q;
    assign dout_ch     = dout_ch_q;
    assign dout_valid  = dout_valid_q;
    assign sat         = sat_q;
    assign coef_err    = coef_err_q;
    assign dbg_state_o = state_q;
endmodule
